// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum_accumulator block: state encodings and default sizing.
`default_nettype none

package sum_accumulator_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_ACCUM = 2'd1;
  localparam state_t S_DONE  = 2'd2;

  localparam int DEF_WIDTH = 5;
  localparam int DEF_N_OPS = 8;
  localparam int CNT_W     = 4;

endpackage

`default_nettype wire

// File: rtl/sum_accumulator_adder.sv
// Ripple-carry adder used as the accumulation datapath (A + B, no carry-in).
`default_nettype none

module adder #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign S[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign Cout = carry[WIDTH];

endmodule

`default_nettype wire

// File: rtl/sum_accumulator.sv
// Accepts a burst of N_OPS operands, accumulates them through the ripple adder
// (wrapping), and presents the total plus a sticky overflow flag on a handshake.
`default_nettype none

module sum_accumulator
  import sum_accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_OPS = DEF_N_OPS
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Clear,
  input  logic [WIDTH-1:0] Din,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] Acc,
  output logic [CNT_W-1:0] Count,
  output logic             Ovf,
  output logic             Out_valid,
  input  logic             Out_ready
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_OPS - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;

  logic [WIDTH-1:0]   sum_w;
  logic               cout_w;
  logic               accept_w;

  adder #(.WIDTH(WIDTH)) u_adder (
    .A    (acc_q),
    .B    (Din),
    .S    (sum_w),
    .Cout (cout_w)
  );

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign accept_w = In_valid & In_ready;

  // Clear takes priority over any handshake; every path back to IDLE zeroes the datapath.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (Clear) begin
      state_d = S_IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_ACCUM: begin
          if (accept_w) begin
            acc_d   = sum_w;
            count_d = count_q + CNT_W'(1);
            ovf_d   = ovf_q | cout_w;
            state_d = (count_q == LAST_IDX) ? S_DONE : S_ACCUM;
          end
        end
        S_DONE: begin
          if (Out_ready) begin
            state_d = S_IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = S_IDLE;
          acc_d   = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    In_ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
    Out_valid = (state_q == S_DONE);
  end

  assign Acc   = acc_q;
  assign Count = count_q;
  assign Ovf   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator (N_OPS=4) against an arithmetic burst model.
`default_nettype none

module tb_sum_accumulator;

  localparam int W = 5;
  localparam int N = 4;

  logic         Clock = 1'b0;
  logic         Reset = 1'b0;
  logic         Clear = 1'b0;
  logic [W-1:0] Din = '0;
  logic         In_valid = 1'b0;
  logic         In_ready;
  logic [W-1:0] Acc;
  logic [3:0]   Count;
  logic         Ovf;
  logic         Out_valid;
  logic         Out_ready = 1'b0;

  int total = 0;
  int bad   = 0;

  int m_acc = 0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;

  wire [11:0] obs = {Acc, Count, Ovf, In_ready, Out_valid};

  sum_accumulator #(.WIDTH(W), .N_OPS(N)) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Clear     (Clear),
    .Din       (Din),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .Acc       (Acc),
    .Count     (Count),
    .Ovf       (Ovf),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Expected {Acc, Count, Ovf, In_ready, Out_valid} from the burst model.
  function automatic logic [11:0] exp_vec();
    bit done;
    done = (m_cnt == N);
    return {5'(m_acc), 4'(m_cnt), m_ovf, !done, done};
  endfunction

  task automatic send(input logic [W-1:0] d);
    Din = d;
    In_valid = 1'b1;
    tick();
    In_valid = 1'b0;
    m_ovf = m_ovf | ((m_acc + int'(d)) > 31);
    m_acc = (m_acc + int'(d)) % 32;
    m_cnt = m_cnt + 1;
  endtask

  task automatic handshake_out();
    Out_ready = 1'b1;
    tick();
    Out_ready = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    #3 Reset = 1'b1;
    #1;
    model_clear();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL reset_async: got %h want %h", obs, exp_vec());
    end
    tick();
    Reset = 1'b0;
    tick();
  endtask

  task automatic test_plain_burst();
    for (int i = 1; i <= N; i++) begin
      send(W'(i));
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL plain_step%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    total++;
    if (Acc !== 5'd10 || Out_valid !== 1'b1 || Ovf !== 1'b0) begin
      bad++;
      $display("FAIL plain_final: got acc=%0d ov=%b ovf=%b want acc=10 ov=1 ovf=0", Acc, Out_valid, Ovf);
    end
    handshake_out();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL plain_release: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] ops [4];
    ops = '{5'd16, 5'd24, 5'd1, 5'd2};
    for (int i = 0; i < N; i++) begin
      send(ops[i]);
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL ovf_step%0d: got %h want %h", i, obs, exp_vec());
      end
    end
    total++;
    if (Acc !== 5'd11 || Ovf !== 1'b1) begin
      bad++;
      $display("FAIL ovf_final: got acc=%0d ovf=%b want acc=11 ovf=1", Acc, Ovf);
    end
    handshake_out();
  endtask

  task automatic test_stall_backpressure();
    for (int i = 1; i <= N; i++) begin
      send(W'(i));
      for (int g = 0; g < 2 && i < N; g++) begin
        tick();
        total++;
        if (obs !== exp_vec()) begin
          bad++;
          $display("FAIL stall_gap%0d_%0d: got %h want %h", i, g, obs, exp_vec());
        end
      end
    end
    In_valid = 1'b1;
    Din = 5'd7;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (obs !== exp_vec() || Acc !== 5'd10 || In_ready !== 1'b0) begin
        bad++;
        $display("FAIL backpressure%0d: got %h want %h", c, obs, exp_vec());
      end
    end
    In_valid = 1'b0;
    handshake_out();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL backpressure_release: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_clear();
    send(5'd1);
    send(5'd2);
    total++;
    if (Acc !== 5'd3) begin
      bad++;
      $display("FAIL clear_pre: got acc=%0d want 3", Acc);
    end
    Clear = 1'b1;
    In_valid = 1'b1;
    Din = 5'd5;
    tick();
    Clear = 1'b0;
    In_valid = 1'b0;
    model_clear();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL clear_result: got %h want %h", obs, exp_vec());
    end
    // Clear while holding a finished total must also beat Out_ready.
    for (int i = 0; i < N; i++) send(5'd9);
    Clear = 1'b1;
    Out_ready = 1'b1;
    tick();
    Clear = 1'b0;
    Out_ready = 1'b0;
    model_clear();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL clear_in_done: got %h want %h", obs, exp_vec());
    end
  endtask

  task automatic test_reset_mid_burst();
    send(5'd7);
    send(5'd9);
    send(5'd11);
    #2 Reset = 1'b1;
    #1;
    model_clear();
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL reset_mid: got %h want %h", obs, exp_vec());
    end
    tick();
    Reset = 1'b0;
    for (int i = 0; i < N; i++) send(5'd20 + W'(i));
    total++;
    if (obs !== exp_vec()) begin
      bad++;
      $display("FAIL reset_mid_reburst: got %h want %h", obs, exp_vec());
    end
    handshake_out();
  endtask

  task automatic test_random_bursts();
    for (int b = 0; b < 8; b++) begin
      for (int i = 0; i < N; i++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        send(W'($urandom_range(0, 31)));
        total++;
        if (obs !== exp_vec()) begin
          bad++;
          $display("FAIL rand_b%0d_op%0d: got %h want %h", b, i, obs, exp_vec());
        end
      end
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) tick();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL rand_b%0d_hold: got %h want %h", b, obs, exp_vec());
      end
      handshake_out();
      total++;
      if (obs !== exp_vec()) begin
        bad++;
        $display("FAIL rand_b%0d_release: got %h want %h", b, obs, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_plain_burst();
    test_overflow();
    test_stall_backpressure();
    test_clear();
    test_reset_mid_burst();
    test_random_bursts();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
